multi_blink_gen: RTL and testbench
==================================

Name: multi_blink_gen

Overview:
- Parametrised N-channel blink generator. Each channel has its own ON/OFF time in ms, set at runtime through a write port.
- Per-channel modes: off, blink, solid and one-shot. A global sync pulse phase-aligns all channels.
- One shared ms prescaler feeds all channels.
- Sits between board-level control logic and LED/GPIO pins. Each channel is replicated onto a fanout group of q outputs.

Parameters:
- F_CLK_HZ, 25_000_000, clock frequency; must be a multiple of 1000 and >= 1000 (elaboration error otherwise).
- N_CH, 3, number of channels, 1..16.
- FANOUT, 3, q bits driven per channel.
- MS_W, 16, width of ON/OFF ms fields.
- DEF_ON_MS, 500, per-channel ON time after reset.
- DEF_OFF_MS, 500, per-channel OFF time after reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- sync  in  1  single-cycle pulse; restarts prescaler and all channels in phase.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  4  target channel index.
- cfg_mode  in  2  0=OFF, 1=BLINK, 2=SOLID, 3=ONESHOT.
- cfg_on_ms  in  MS_W  ON time.
- cfg_off_ms  in  MS_W  OFF time.
- wave  out  N_CH  per-channel waveform, registered.
- q  out  N_CH*FANOUT  q[c*FANOUT +: FANOUT] = {FANOUT{wave[c]}}.
- done  out  N_CH  one-shot completed flag, registered.
- ms_tick  out  1  prescaler pulse, 1 cycle wide every TICKS_PER_MS clocks.

Behaviour:
- Single clock; reset is synchronous, active-low.
- TICKS_PER_MS = F_CLK_HZ/1000. The prescaler counts 0..TICKS_PER_MS-1; ms_tick is high on the cycle the count equals TICKS_PER_MS-1.
- Reset values (while rst_n=0): wave=0, q=0, done=0, ms_tick=0, prescaler=0.
  - Every channel: mode=BLINK, on=DEF_ON_MS, off=DEF_OFF_MS, state=ON, cnt=0, no pending config.
- Channel FSM states: ON, OFF, DONE. cnt is an MS_W-bit ms counter that advances only on ms_tick.
- BLINK:
  - In ON with ms_tick and cnt==on-1: go to OFF, cnt=0.
  - In OFF with ms_tick and cnt==off-1: go to ON, cnt=0, and apply pending on/off.
  - Otherwise, on ms_tick, cnt+1.
- Output mapping: wave=1 in ON, 0 in OFF. wave is registered, so it lags the state by exactly 1 cycle.
- Degenerate times in BLINK:
  - on=0: wave constant 0.
  - off=0 with on>0: wave constant 1.
  - on=0 and off=0: wave 0.
  - The counter still runs so that later config applies cleanly.
- SOLID: wave=1. OFF mode: wave=0. In both modes the channel is held at state=ON, cnt=0.
- ONESHOT:
  - Entering the mode (write) or a sync starts ON, cnt=0, done=0.
  - After on ms the channel goes to DONE: wave=0, done=1.
  - It stays in DONE until the next sync or mode write.
- Config write, when cfg_we=1 and cfg_ch<N_CH:
  - Mode takes effect on the next cycle.
  - on/off go to a per-channel pending register and are applied at the next OFF→ON boundary, so no truncated or glitched phase is produced.
  - A write that changes mode also applies on/off immediately and restarts the channel at ON, cnt=0.
  - A write with cfg_ch>=N_CH is ignored.
- Back-to-back writes to the same channel before the boundary: the last write wins.
- sync:
  - Prescaler resets to 0 (the next ms_tick arrives TICKS_PER_MS cycles later).
  - Every channel goes to ON, cnt=0, done=0, with pending config applied.
  - When sync and cfg_we occur in the same cycle, the write is applied first; the synced channel uses the new values.
- Counter arithmetic: no overflow is possible, because cnt < max(on,off) <= 2^MS_W-1.
- Reset mid-operation discards pending config and restores DEF_* values.

Decomposition:
- Package multi_blink_pkg:
  - mode_e (2-bit enum OFF/BLINK/SOLID/ONESHOT).
  - state_e (ON/OFF/DONE).
  - function ticks_per_ms(f_clk_hz).
  - localparam widths for cfg_ch.
- Sub-module blink_channel: one FSM, cnt, live and pending config, registered wave/done. Instantiated N_CH times in a generate loop.
- Top level holds the prescaler, write decode, q fanout and parameter checks.

Test Plan (F_CLK_HZ=4000 → TICKS_PER_MS=4; DEF_ON_MS=3, DEF_OFF_MS=2; N_CH=3):
1. Release reset → every wave is high for 12 clocks then low for 8, periodically; q[8:6]==q[5:3]==q[2:0]==3'b111 while high; ms_tick fires every 4th clock.
2. Write ch1 on=1/off=5 mid-ON phase → current ch1 period completes at 3/2. From the next ON onward, ch1 is high 4 clocks and low 20; ch0 and ch2 are unaffected.
3. Write ch2 mode=ONESHOT with on=2 → wave[2] is high 8 clocks then stays low with done[2]=1. A sync pulse clears done[2] and wave[2] is high again for 8 clocks.
4. Desynchronise the channels with differing writes, then pulse sync → all BLINK waves rise 1 cycle after sync, and the next ms_tick occurs exactly 4 clocks after sync.
5. Boundaries: ch0 on=0 → wave[0] stuck 0; ch0 on=3/off=0 → stuck 1; cfg_ch=3 write → no state change; mode=SOLID → 1; mode=OFF → 0.
6. Assert rst_n=0 mid-OFF with pending config → all outputs are 0 during reset. After release, DEF 3/2 timing resumes and the pending config is never applied.

Source files
------------

// File: rtl/multi_blink_pkg.sv
// Shared types and helpers for the multi-channel blink generator.
package multi_blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_SOLID   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_ON   = 2'd0,
        ST_OFF  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int CH_W   = 4;
    localparam int MAX_CH = 16;

    function automatic int ticks_per_ms(input int f_clk_hz);
        return f_clk_hz / 1000;
    endfunction

endpackage

// File: rtl/multi_blink_gen_channel.sv
// One blink channel: ON/OFF/DONE FSM with an ms counter, live and pending
// timing config, and registered wave/done outputs.
module blink_channel
    import multi_blink_pkg::*;
#(
    parameter int MS_W       = 16,
    parameter int DEF_ON_MS  = 500,
    parameter int DEF_OFF_MS = 500
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_tick,
    input  logic            i_sync,
    input  logic            i_we,
    input  mode_e           i_mode,
    input  logic [MS_W-1:0] i_on_ms,
    input  logic [MS_W-1:0] i_off_ms,
    output logic            o_wave,
    output logic            o_done
);

    localparam logic [MS_W-1:0] DEF_ON  = MS_W'(DEF_ON_MS);
    localparam logic [MS_W-1:0] DEF_OFF = MS_W'(DEF_OFF_MS);
    localparam logic [MS_W-1:0] ZERO    = {MS_W{1'b0}};
    localparam logic [MS_W-1:0] ONE     = MS_W'(1);

    mode_e           r_mode,     w_mode;
    state_e          r_state,    w_state;
    logic [MS_W-1:0] r_cnt,      w_cnt;
    logic [MS_W-1:0] r_on,       w_on;
    logic [MS_W-1:0] r_off,      w_off;
    logic [MS_W-1:0] r_pend_on,  w_pend_on;
    logic [MS_W-1:0] r_pend_off, w_pend_off;
    logic            r_wave,     w_wave;
    logic            r_done,     w_done;
    logic            w_restart;
    logic            w_on_end;
    logic            w_off_end;

    // Zero-length phases end on the first tick so the counter never wraps.
    assign w_on_end  = (r_on  == ZERO) || (r_cnt == r_on  - ONE);
    assign w_off_end = (r_off == ZERO) || (r_cnt == r_off - ONE);

    // Next-state logic: config capture, restart, and tick-driven phase steps.
    always_comb begin
        w_mode     = r_mode;
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_on       = r_on;
        w_off      = r_off;
        w_pend_on  = r_pend_on;
        w_pend_off = r_pend_off;
        w_restart  = 1'b0;
        if (i_we) begin
            w_mode     = i_mode;
            w_pend_on  = i_on_ms;
            w_pend_off = i_off_ms;
            w_restart  = (i_mode != r_mode) || (i_mode == MODE_ONESHOT);
        end else begin
            w_restart  = 1'b0;
        end
        if (w_restart || i_sync) begin
            w_state = ST_ON;
            w_cnt   = ZERO;
            w_on    = w_pend_on;
            w_off   = w_pend_off;
        end else if ((r_mode == MODE_OFF) || (r_mode == MODE_SOLID)) begin
            w_state = ST_ON;
            w_cnt   = ZERO;
        end else if (i_tick) begin
            case (r_state)
                ST_ON: begin
                    if (w_on_end) begin
                        w_state = (r_mode == MODE_ONESHOT) ? ST_DONE : ST_OFF;
                        w_cnt   = ZERO;
                    end else begin
                        w_cnt   = r_cnt + ONE;
                    end
                end
                ST_OFF: begin
                    // Pending timing lands only here, so no phase is cut short.
                    if (w_off_end) begin
                        w_state = ST_ON;
                        w_cnt   = ZERO;
                        w_on    = w_pend_on;
                        w_off   = w_pend_off;
                    end else begin
                        w_cnt   = r_cnt + ONE;
                    end
                end
                ST_DONE: begin
                    w_state = ST_DONE;
                    w_cnt   = ZERO;
                end
                default: begin
                    w_state = ST_ON;
                    w_cnt   = ZERO;
                end
            endcase
        end else begin
            w_state = r_state;
            w_cnt   = r_cnt;
        end
    end

    // Output decode from the current registered state and mode.
    always_comb begin
        w_wave = 1'b0;
        w_done = 1'b0;
        case (r_mode)
            MODE_OFF:     w_wave = 1'b0;
            MODE_SOLID:   w_wave = 1'b1;
            MODE_BLINK:   w_wave = (r_on != ZERO) && ((r_state == ST_ON) || (r_off == ZERO));
            MODE_ONESHOT: begin
                w_wave = (r_on != ZERO) && (r_state == ST_ON);
                w_done = (r_state == ST_DONE);
            end
            default:      w_wave = 1'b0;
        endcase
    end

    // State, config and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode     <= MODE_BLINK;
            r_state    <= ST_ON;
            r_cnt      <= ZERO;
            r_on       <= DEF_ON;
            r_off      <= DEF_OFF;
            r_pend_on  <= DEF_ON;
            r_pend_off <= DEF_OFF;
            r_wave     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_mode     <= w_mode;
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_on       <= w_on;
            r_off      <= w_off;
            r_pend_on  <= w_pend_on;
            r_pend_off <= w_pend_off;
            r_wave     <= w_wave;
            r_done     <= w_done;
        end
    end

    assign o_wave = r_wave;
    assign o_done = r_done;

endmodule

// File: rtl/multi_blink_gen.sv
// N-channel blink generator: shared ms prescaler, config write decode,
// per-channel blink FSMs and output fanout.
module multi_blink_gen
    import multi_blink_pkg::*;
#(
    parameter int F_CLK_HZ   = 25_000_000,
    parameter int N_CH       = 3,
    parameter int FANOUT     = 3,
    parameter int MS_W       = 16,
    parameter int DEF_ON_MS  = 500,
    parameter int DEF_OFF_MS = 500
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sync,
    input  logic                   cfg_we,
    input  logic [CH_W-1:0]        cfg_ch,
    input  logic [1:0]             cfg_mode,
    input  logic [MS_W-1:0]        cfg_on_ms,
    input  logic [MS_W-1:0]        cfg_off_ms,
    output logic [N_CH-1:0]        wave,
    output logic [N_CH*FANOUT-1:0] q,
    output logic [N_CH-1:0]        done,
    output logic                   ms_tick
);

    localparam int TICKS_PER_MS = ticks_per_ms(F_CLK_HZ);
    localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MS - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [CH_W:0] N_CH_L     = (CH_W + 1)'(N_CH);

    if ((F_CLK_HZ < 1000) || ((F_CLK_HZ % 1000) != 0)) begin : g_bad_fclk
        $error("multi_blink_gen: F_CLK_HZ must be a multiple of 1000 and >= 1000");
    end
    if ((N_CH < 1) || (N_CH > MAX_CH)) begin : g_bad_nch
        $error("multi_blink_gen: N_CH must be within 1..16");
    end
    if (FANOUT < 1) begin : g_bad_fanout
        $error("multi_blink_gen: FANOUT must be at least 1");
    end

    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc;
    logic          r_tick;
    logic          w_ch_valid;
    mode_e         w_mode;

    // Prescaler next value; sync realigns it to the start of a ms.
    always_comb begin
        if (sync) begin
            w_presc = {PW{1'b0}};
        end else if (r_presc == PRESC_LAST) begin
            w_presc = {PW{1'b0}};
        end else begin
            w_presc = r_presc + PRESC_ONE;
        end
    end

    // The tick flop is loaded from the next count so it lines up with count==last.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= {PW{1'b0}};
            r_tick  <= 1'b0;
        end else begin
            r_presc <= w_presc;
            r_tick  <= (w_presc == PRESC_LAST);
        end
    end

    assign ms_tick    = r_tick;
    assign w_ch_valid = ({1'b0, cfg_ch} < N_CH_L);
    assign w_mode     = mode_e'(cfg_mode);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic w_we;

        assign w_we = cfg_we && w_ch_valid && (cfg_ch == CH_W'(c));

        blink_channel #(
            .MS_W       (MS_W),
            .DEF_ON_MS  (DEF_ON_MS),
            .DEF_OFF_MS (DEF_OFF_MS)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_tick   (r_tick),
            .i_sync   (sync),
            .i_we     (w_we),
            .i_mode   (w_mode),
            .i_on_ms  (cfg_on_ms),
            .i_off_ms (cfg_off_ms),
            .o_wave   (wave[c]),
            .o_done   (done[c])
        );

        assign q[c*FANOUT +: FANOUT] = {FANOUT{wave[c]}};
    end

endmodule

// File: tb/tb_multi_blink_gen.sv
// Directed bench for multi_blink_gen at 4 ticks/ms, DEF 3/2 ms, 3 channels.
module tb_multi_blink_gen;
    import multi_blink_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_ch = 4'd0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [15:0] cfg_on_ms = 16'd0;
    logic [15:0] cfg_off_ms = 16'd0;
    logic [2:0]  wave;
    logic [8:0]  q;
    logic [2:0]  done;
    logic        ms_tick;

    int n_checks = 0;
    int n_errors = 0;
    int k = 0;

    typedef struct {
        logic       sy;
        logic [3:0] ch;
        logic [1:0] mode;
        int         on;
        int         off;
        logic       exp_w0;
    } vec_t;

    vec_t tbl [6];

    multi_blink_gen #(
        .F_CLK_HZ   (4000),
        .N_CH       (3),
        .FANOUT     (3),
        .MS_W       (16),
        .DEF_ON_MS  (3),
        .DEF_OFF_MS (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync       (sync),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_on_ms  (cfg_on_ms),
        .cfg_off_ms (cfg_off_ms),
        .wave       (wave),
        .q          (q),
        .done       (done),
        .ms_tick    (ms_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at k=%0d: got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        k++;
    endtask

    function automatic logic [8:0] fan(input logic [2:0] w);
        logic [8:0] f;
        for (int c = 0; c < 3; c++) f[c*3 +: 3] = {3{w[c]}};
        return f;
    endfunction

    task automatic wr(input int ch, input logic [1:0] m, input int on, input int off, input logic sy);
        cfg_we     = 1'b1;
        cfg_ch     = 4'(ch);
        cfg_mode   = m;
        cfg_on_ms  = 16'(on);
        cfg_off_ms = 16'(off);
        sync       = sy;
        step();
        cfg_we     = 1'b0;
        sync       = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) begin
            step();
            chk("rst_wave", 32'(wave), 32'd0);
            chk("rst_q", 32'(q), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_tick", 32'(ms_tick), 32'd0);
        end
        rst_n = 1'b1;
        k = 0;
    endtask

    task automatic def_now();
        logic [2:0] ew;
        ew = (k >= 1 && ((k - 1) % 20) < 12) ? 3'b111 : 3'b000;
        chk("def_wave", 32'(wave), 32'(ew));
        chk("def_q", 32'(q), 32'(fan(ew)));
        chk("def_tick", 32'(ms_tick), 32'(k % 4 == 3));
        chk("def_done", 32'(done), 32'd0);
    endtask

    task automatic check_def(input int last);
        def_now();
        while (k < last) begin
            step();
            def_now();
        end
    endtask

    task automatic t3_now();
        chk("oneshot_wave2", 32'(wave[2]), 32'(k >= 117 && k <= 124));
        chk("oneshot_done2", 32'(done[2]), 32'(k >= 125));
    endtask

    task automatic t3b_now();
        chk("resync_wave2", 32'(wave[2]), 32'(k >= 138 && k <= 145));
        chk("resync_done2", 32'(done[2]), 32'(k == 137 || k >= 146));
        chk("resync_tick", 32'(ms_tick), 32'((k - 137) % 4 == 3));
    endtask

    task automatic t4_now();
        logic [2:0] ew;
        ew[0] = (k <= 166) || (k >= 175 && k <= 182);
        ew[1] = (k <= 162) || (k >= 183);
        ew[2] = (k <= 170) || (k >= 179);
        chk("sync_wave", 32'(wave), 32'(ew));
        chk("sync_tick", 32'(ms_tick), 32'((k - 158) % 4 == 3));
    endtask

    initial begin
        logic e0;
        logic e1;

        tbl[0] = '{sy: 1'b1, ch: 4'd0, mode: 2'd1, on: 0, off: 2, exp_w0: 1'b0};
        tbl[1] = '{sy: 1'b1, ch: 4'd0, mode: 2'd1, on: 3, off: 0, exp_w0: 1'b1};
        tbl[2] = '{sy: 1'b0, ch: 4'd3, mode: 2'd0, on: 0, off: 0, exp_w0: 1'b1};
        tbl[3] = '{sy: 1'b0, ch: 4'd0, mode: 2'd2, on: 0, off: 0, exp_w0: 1'b1};
        tbl[4] = '{sy: 1'b0, ch: 4'd0, mode: 2'd0, on: 3, off: 2, exp_w0: 1'b0};
        tbl[5] = '{sy: 1'b0, ch: 4'd0, mode: 2'd1, on: 0, off: 0, exp_w0: 1'b0};

        // Reset values, then default 3/2 ms blinking on all channels.
        do_reset();
        check_def(44);

        // ch1 timing change mid-ON is deferred to the next OFF->ON boundary.
        wr(1, 2'd1, 1, 5, 1'b0);
        while (k < 108) begin
            step();
            e0 = ((k - 1) % 20) < 12;
            e1 = (k <= 60) ? e0 : (((k - 61) % 24) < 4);
            chk("retime_wave", 32'(wave), 32'({e0, e1, e0}));
        end

        // ch2 one-shot of 2 ms, written on a tick cycle while in OFF.
        while (k < 115) step();
        wr(2, 2'd3, 2, 5, 1'b0);
        t3_now();
        while (k < 135) begin
            step();
            t3_now();
        end

        // sync re-arms the one-shot and realigns the prescaler.
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        t3b_now();
        while (k < 150) begin
            step();
            t3b_now();
        end

        // Desynchronise, then sync: all channels restart together.
        wr(2, 2'd1, 3, 2, 1'b0);
        wr(0, 2'd1, 2, 2, 1'b0);
        while (k < 157) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("sync_tick_first", 32'(ms_tick), 32'd0);
        step();
        t4_now();
        while (k < 183) begin
            step();
            t4_now();
        end

        // Boundary table on ch0: degenerate times, bad channel, SOLID, OFF.
        for (int i = 0; i < 6; i++) begin
            wr(int'(tbl[i].ch), tbl[i].mode, tbl[i].on, tbl[i].off, tbl[i].sy);
            step();
            repeat (24) begin
                step();
                chk($sformatf("bound%0d_wave0", i), 32'(wave[0]), 32'(tbl[i].exp_w0));
                chk($sformatf("bound%0d_done0", i), 32'(done[0]), 32'd0);
            end
        end

        // Reset with pending config: defaults return, pending is dropped.
        wr(1, 2'd1, 7, 7, 1'b0);
        step();
        step();
        do_reset();
        check_def(44);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
